cic_interp_s4: RTL and testbench

CIC_INTERP_S4 -- requirements
Module: cic_interp_s4

---
 rtl/cic_interp_s4.sv | 71 +++++++
 tb/tb_cic_interp_s4.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/cic_interp_s4.sv
// Two-stage CIC interpolator (comb x2, zero-stuff by FACTOR, integrator x2), wrapping arithmetic.
// Latency: sample taken at edge t reaches filter_out after edge t+2; no backpressure, clk_enable paces everything.
module cic_interp_s4 #(
    parameter int INPUT_WIDTH  = 12,
    parameter int OUTPUT_WIDTH = 28
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clk_enable,
    input  logic [15:0]             FACTOR,
    input  logic [INPUT_WIDTH-1:0]  filter_in,
    output logic                    in_ready,
    output logic [OUTPUT_WIDTH-1:0] filter_out,
    output logic                    ce_out
);

    generate
        if (OUTPUT_WIDTH < INPUT_WIDTH + 16) begin : g_width_check
            $error("OUTPUT_WIDTH must be at least INPUT_WIDTH + 16");
        end
    endgenerate

    logic [15:0]             counter;
    logic [15:0]             last_phase;
    logic                    phase_0;
    logic [OUTPUT_WIDTH-1:0] x_ext;
    logic [OUTPUT_WIDTH-1:0] d1;
    logic [OUTPUT_WIDTH-1:0] d2;
    logic [OUTPUT_WIDTH-1:0] comb1;
    logic [OUTPUT_WIDTH-1:0] comb2;
    logic [OUTPUT_WIDTH-1:0] stuff_reg;
    logic [OUTPUT_WIDTH-1:0] i1;
    logic [OUTPUT_WIDTH-1:0] i2;

    // FACTOR of 0 is treated as 1, so the last phase index is 0 in both cases.
    assign last_phase = (FACTOR == 16'd0) ? 16'd0 : FACTOR - 16'd1;
    assign phase_0    = (counter == 16'd0) && clk_enable;
    assign in_ready   = phase_0;

    assign x_ext = {{(OUTPUT_WIDTH-INPUT_WIDTH){filter_in[INPUT_WIDTH-1]}}, filter_in};
    assign comb1 = x_ext - d1;
    assign comb2 = comb1 - d2;

    assign filter_out = i2;

    always_ff @(posedge clk) begin
        if (reset) begin
            counter   <= '0;
            d1        <= '0;
            d2        <= '0;
            stuff_reg <= '0;
            i1        <= '0;
            i2        <= '0;
            ce_out    <= 1'b0;
        end else begin
            ce_out <= clk_enable;
            if (clk_enable) begin
                // ">=" lets a FACTOR reduction below the current count wrap immediately.
                counter <= (counter >= last_phase) ? 16'd0 : counter + 16'd1;
                if (phase_0) begin
                    d1 <= x_ext;
                    d2 <= comb1;
                end
                stuff_reg <= phase_0 ? comb2 : '0;
                i1        <= i1 + stuff_reg;
                i2        <= i2 + i1;
            end
        end
    end

endmodule

// File: tb/tb_cic_interp_s4.sv
// Directed bench for cic_interp_s4: prefix-sum reference model checked every cycle plus literal expectations.
module tb_cic_interp_s4;

    localparam int IW = 12;
    localparam int OW = 28;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clk_enable = 1'b0;
    logic [15:0]   FACTOR = '0;
    logic [IW-1:0] filter_in = '0;
    logic          in_ready;
    logic [OW-1:0] filter_out;
    logic          ce_out;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    cic_interp_s4 #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW)) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .FACTOR     (FACTOR),
        .filter_in  (filter_in),
        .in_ready   (in_ready),
        .filter_out (filter_out),
        .ce_out     (ce_out)
    );

    // Reference: output after enabled tick k is sum over m<=k-2 of (k-1-m)*s[m],
    // kept incrementally as out += P[k-2] with P the prefix sum of stuffed samples.
    int     m_cnt = 0;
    longint m_x1 = 0, m_x2 = 0;
    longint m_pa = 0, m_pb = 0;
    longint m_out = 0;
    bit     m_ce = 1'b0;

    always @(posedge clk) begin
        int     reff;
        longint xs;
        longint sn;
        if (reset) begin
            m_cnt = 0; m_x1 = 0; m_x2 = 0;
            m_pa = 0; m_pb = 0; m_out = 0; m_ce = 1'b0;
        end else begin
            m_ce = clk_enable;
            if (clk_enable) begin
                reff = (FACTOR == 16'd0) ? 1 : int'(FACTOR);
                xs   = longint'($signed(filter_in));
                sn   = (m_cnt == 0) ? (xs - 2 * m_x1 + m_x2) : 0;
                if (m_cnt == 0) begin
                    m_x2 = m_x1;
                    m_x1 = xs;
                end
                m_out = m_out + m_pa;
                m_pa  = m_pb;
                m_pb  = m_pb + sn;
                m_cnt = (m_cnt >= reff - 1) ? 0 : m_cnt + 1;
            end
        end
    end

    always begin
        logic [OW-1:0] exp_out;
        @(negedge clk);
        #3;
        if (chk_en) begin
            exp_out = OW'(m_out);
            checks++;
            if (filter_out !== exp_out) begin
                errors++;
                $display("FAIL model_out: got %0d expected %0d at %0t", $signed(filter_out), $signed(exp_out), $time);
            end
            checks++;
            if (ce_out !== m_ce) begin
                errors++;
                $display("FAIL model_ce: got %b expected %b at %0t", ce_out, m_ce, $time);
            end
            checks++;
            if (in_ready !== (clk_enable && m_cnt == 0)) begin
                errors++;
                $display("FAIL model_in_ready: got %b expected %b at %0t", in_ready, (clk_enable && m_cnt == 0), $time);
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit e, input int f, input int x);
        @(negedge clk);
        #1;
        reset      = r;
        clk_enable = e;
        FACTOR     = 16'(f);
        filter_in  = IW'(x);
    endtask

    function automatic longint outv();
        return longint'($signed(filter_out));
    endfunction

    initial begin
        int imp_exp[10]  = '{1, 2, 3, 4, 3, 2, 1, 0, 0, 0};
        int step_exp[7]  = '{100, 200, 300, 400, 400, 400, 400};
        int rst_exp[4]   = '{1, 2, 3, 4};
        int dly_in[8]    = '{5, -7, 300, -2048, 2047, -1, 0, 0};
        int gate_exp[8]  = '{10, 10, 20, 20, 30, 30, 30, 30};
        int fvals[2]     = '{0, 1};
        int ir_count;

        // Reset state and impulse response, FACTOR=4
        step(1, 1, 4, 0);
        step(0, 1, 4, 1);
        chk_en = 1'b1;
        chk("reset_out", outv(), 0);
        chk("reset_ce", longint'(ce_out), 0);
        #1;
        chk("reset_in_ready", longint'(in_ready), 1);
        for (int k = 1; k <= 12; k++) begin
            step(0, 1, 4, 0);
            if (k >= 3) chk("impulse", outv(), imp_exp[k-3]);
        end

        // Step response, FACTOR=4, in_ready every 4th cycle
        step(1, 1, 4, 0);
        step(0, 1, 4, 100);
        ir_count = 0;
        for (int k = 1; k <= 9; k++) begin
            step(0, 1, 4, 100);
            if (k >= 3) chk("step", outv(), step_exp[k-3]);
            #1;
            if (k <= 8 && in_ready) ir_count++;
        end
        chk("step_in_ready_count", ir_count, 2);

        // Reset mid-ramp restarts the response
        step(0, 1, 4, 1);
        step(0, 1, 4, 1);
        step(1, 1, 4, 1);
        step(0, 1, 4, 1);
        chk("midreset_out", outv(), 0);
        chk("midreset_ce", longint'(ce_out), 0);
        #1;
        chk("midreset_in_ready", longint'(in_ready), 1);
        for (int k = 1; k <= 6; k++) begin
            step(0, 1, 4, 1);
            if (k >= 3) chk("midreset_ramp", outv(), rst_exp[k-3]);
        end

        // FACTOR=0 and FACTOR=1: pure delay
        foreach (fvals[i]) begin
            step(1, 1, fvals[i], 0);
            for (int k = 0; k < 8; k++) begin
                step(0, 1, fvals[i], dly_in[k]);
                if (k >= 3) chk($sformatf("delay_f%0d", fvals[i]), outv(), dly_in[k-3]);
            end
        end

        // Enable gating, FACTOR=3, each value held for two clocks
        step(1, 1, 3, 0);
        for (int k = 0; k <= 12; k++) begin
            step(0, (k % 2) == 0, 3, 10);
            if (k >= 5) chk("gate_out", outv(), gate_exp[k-5]);
            if (k == 5) chk("gate_ce_hi", longint'(ce_out), 1);
            if (k == 6) chk("gate_ce_lo", longint'(ce_out), 0);
        end

        // FACTOR change 8 -> 2 while the counter sits at 5
        step(1, 1, 8, 0);
        for (int k = 0; k < 5; k++) step(0, 1, 8, 0);
        step(0, 1, 2, 0);
        #1;
        chk("fchg_at5", longint'(in_ready), 0);
        step(0, 1, 2, 0);
        #1;
        chk("fchg_wrap", longint'(in_ready), 1);
        step(0, 1, 2, 0);
        #1;
        chk("fchg_gap", longint'(in_ready), 0);
        step(0, 1, 2, 0);
        #1;
        chk("fchg_next", longint'(in_ready), 1);

        // Full-scale negative input, FACTOR=65535
        step(1, 1, 65535, 0);
        for (int k = 0; k < 65538; k++) step(0, 1, 65535, -2048);
        chk("neg_settle", outv(), -134215680);

        @(negedge clk);
        #4;
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
